// File: rtl/common_types_pkg.sv
// Shared execute-stage types: divider state encoding, widths and a sign helper.
package common_types_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  // Two's-complement negate x when c is set.
  function automatic logic [DIV_W-1:0] neg_if(input logic c, input logic [DIV_W-1:0] x);
    return c ? (~x + DIV_W'(1)) : x;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Core <-> divider handshake bundle: start/flush/operands in, results/ready out.
interface divider_if;
  import common_types_pkg::*;

  logic             en;
  logic             flush;
  logic             is_signed;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             ready;

  modport div  (input  en, flush, dividend, divisor, is_signed,
                output quotient, remainder, ready);
  modport core (output en, flush, dividend, divisor, is_signed,
                input  quotient, remainder, ready);

endinterface

// File: rtl/divider.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are applied in a final fix-up cycle.
module divider
  import common_types_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             flush,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             is_signed,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             ready
);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]       rem_q, rem_d;
  logic [DIV_W-1:0]     quo_q, quo_d;
  logic [DIV_W-1:0]     bmag_q, bmag_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [DIV_W-1:0]     quotient_q, quotient_d;
  logic [DIV_W-1:0]     remainder_q, remainder_d;
  logic                 ready_q, ready_d;

  logic                 a_neg, b_neg, overflow;
  logic [DIV_W:0]       shifted, trial;

  // Next-state, datapath step and output update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bmag_d      = bmag_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    a_neg    = is_signed & dividend[DIV_W-1];
    b_neg    = is_signed & divisor[DIV_W-1];
    overflow = is_signed && (dividend == {1'b1, {(DIV_W-1){1'b0}}}) && (divisor == '1);
    shifted  = {rem_q[DIV_W-1:0], quo_q[DIV_W-1]};
    trial    = shifted - {1'b0, bmag_q};

    unique case (state_q)
      DIV_IDLE: begin
        if (en && !flush) begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bmag_d    = neg_if(b_neg, divisor);
          cnt_d     = DIV_CNT_W'(DIV_ITERS - 1);
          if (divisor == '0) begin
            quo_d     = '1;
            rem_d     = {1'b0, dividend};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_FIX;
          end else if (overflow) begin
            quo_d     = dividend;
            rem_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_FIX;
          end else begin
            quo_d   = neg_if(a_neg, dividend);
            rem_d   = '0;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          // Restore by keeping the shifted value when the trial subtract borrows.
          quo_d = {quo_q[DIV_W-2:0], ~trial[DIV_W]};
          rem_d = trial[DIV_W] ? shifted : trial;
          cnt_d = cnt_q - DIV_CNT_W'(1);
          if (cnt_q == '0) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = DIV_IDLE;
        if (!flush) begin
          quotient_d  = neg_if(neg_quo_q, quo_q);
          remainder_d = neg_if(neg_rem_q, rem_q[DIV_W-1:0]);
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    ready_d = (state_d == DIV_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bmag_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bmag_q      <= bmag_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: RV32M arithmetic reference model plus per-cycle output compare.
module tb_divider;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  divider_if bus();

  divider dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (bus.en),
    .flush     (bus.flush),
    .dividend  (bus.dividend),
    .divisor   (bus.divisor),
    .is_signed (bus.is_signed),
    .quotient  (bus.quotient),
    .remainder (bus.remainder),
    .ready     (bus.ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RV32M result and busy-cycle count for one operation.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (s) begin
      q = 32'(sa / sb); r = 32'(sa % sb); lat = 33;
    end else begin
      q = a / b; r = a % b; lat = 33;
    end
  endfunction

  // Cycle-level model: an accepted op stays busy for its latency, flush cancels it.
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_q = 32'd0, m_r = 32'd0, p_q = 32'd0, p_r = 32'd0;
  int          p_lat;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 1'b0; m_left = 0; m_q = 32'd0; m_r = 32'd0;
    end else if (m_busy) begin
      if (bus.flush) begin
        m_busy = 1'b0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_q = p_q; m_r = p_r;
        end
      end
    end else if (bus.en && !bus.flush) begin
      ref_div(bus.dividend, bus.divisor, bus.is_signed, p_q, p_r, p_lat);
      m_busy = 1'b1;
      m_left = p_lat;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    check("ready", 32'(bus.ready), 32'(!m_busy));
    check("quotient", bus.quotient, m_q);
    check("remainder", bus.remainder, m_r);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input int elat,
                        input string name);
    int lat;
    bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    lat = 0;
    while (!bus.ready && lat < 100) begin
      lat++;
      tick();
    end
    check({name, "_latency"}, 32'(lat), 32'(elat));
    check({name, "_q"}, bus.quotient, eq);
    check({name, "_r"}, bus.remainder, er);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, a, b;
    int lat, lat1, lat2, k;
    logic s;

    bus.en = 1'b0; bus.flush = 1'b0; bus.is_signed = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;

    // Pin the reference model against hand-computed values.
    ref_div(32'd100, 32'd7, 1'b0, q, r, lat);
    check("model_100_7_q", q, 32'd14);
    check("model_100_7_r", r, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat);
    check("model_m7_2_q", q, 32'hFFFF_FFFD);
    check("model_m7_2_r", r, 32'hFFFF_FFFF);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, lat);
    check("model_ovf_u_r", r, 32'h8000_0000);
    check("model_ovf_u_lat", 32'(lat), 32'd33);

    tick();
    tick();
    nrst = 1'b1;
    tick();
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_q", bus.quotient, 32'd0);
    check("reset_r", bus.remainder, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, "divu_100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, "div_7_m2");
    run_op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1, "div_by0_s");
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1, "div_by0_u");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1, "ovf_s");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33, "ovf_u");

    // Flush during RUN iteration 5 keeps the previous result.
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, "pre_flush");
    bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.is_signed = 1'b0; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    repeat (4) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_ready", 32'(bus.ready), 32'd1);
    check("flush_q", bus.quotient, 32'd14);
    check("flush_r", bus.remainder, 32'd2);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    repeat (3) tick();
    #2 nrst = 1'b0;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_q", bus.quotient, 32'd0);
    check("arst_r", bus.remainder, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // en held high across two ops; operands changed while busy.
    bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b0; bus.en = 1'b1;
    tick();
    bus.dividend = 32'd1000; bus.divisor = 32'd3;
    lat1 = 0;
    while (!bus.ready && lat1 < 100) begin lat1++; tick(); end
    check("b2b_first_q", bus.quotient, 32'd14);
    check("b2b_first_r", bus.remainder, 32'd2);
    tick();
    bus.en = 1'b0;
    lat2 = 0;
    while (!bus.ready && lat2 < 100) begin lat2++; tick(); end
    check("b2b_first_lat", 32'(lat1), 32'd33);
    check("b2b_total_lat", 32'(lat1 + lat2), 32'd66);
    check("b2b_second_q", bus.quotient, 32'd333);
    check("b2b_second_r", bus.remainder, 32'd1);

    // Randomized operations with occasional aborts.
    for (int i = 0; i < 200; i++) begin
      a = pick();
      b = pick();
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        k = $urandom_range(0, 34);
        for (int j = 0; j < k && !bus.ready; j++) tick();
        if (!bus.ready) begin
          bus.flush = 1'b1;
          tick();
          bus.flush = 1'b0;
          check("rand_flush_ready", 32'(bus.ready), 32'd1);
        end
      end else begin
        ref_div(a, b, s, q, r, lat);
        run_op(a, b, s, q, r, lat, "rand");
      end
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse-direction companion to the Booth multiplier in the execute stage and shares its start/ready handshake. The core asserts `en` with the operands, then stalls while `ready` is low. Quotient and remainder are registered and held until the next accepted operation.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk` input 1: clock, rising edge.
- `nrst` input 1: asynchronous active-low reset.
- `en` input 1: start request, sampled only while `ready`=1.
- `flush` input 1: abort the in-flight operation (pipeline kill).
- `dividend` input 32: operand a.
- `divisor` input 32: operand b.
- `is_signed` input 1: 1 = DIV/REM semantics, 0 = DIVU/REMU.
- `quotient` output 32: registered quotient. Reset value 0.
- `remainder` output 32: registered remainder. Reset value 0.
- `ready` output 1: idle and outputs valid. Reset value 1.
- All signals except clock and reset are bundled in `divider_if`, with modports `div` (this block) and `core`.

## Operation
**States: DIV_IDLE, DIV_RUN, DIV_FIX.** `ready` = (state == DIV_IDLE).

**DIV_IDLE with `en`=1 (edge E0):** operands and the sign flags are latched.
- Sign flags: `neg_q` = is_signed & (a[31] ^ b[31]); `neg_r` = is_signed & a[31].
- Divide by zero (b == 0): load q = 0xFFFFFFFF and r = a, then go to DIV_FIX with the sign fix suppressed.
- Signed overflow (is_signed, a = 0x80000000, b = 0xFFFFFFFF): load q = 0x80000000 and r = 0, then go to DIV_FIX with the sign fix suppressed.
- Otherwise: load magnitudes (two's-complement negate a and/or b if is_signed and negative), clear the 33-bit partial remainder, set the iteration counter to 31, and go to DIV_RUN.

**DIV_RUN, each edge:**
- Shift {rem, quo} left by 1.
- trial = rem_shifted − {1'b0, |b|}.
- If trial[32] = 0: rem = trial and quo[0] = 1.
- Decrement the counter. Go to DIV_FIX after the iteration with counter = 0 (32 iterations total).

**DIV_FIX:**
- quotient ← neg_q ? −quo : quo.
- remainder ← neg_r ? −rem[31:0] : rem[31:0].
- Go to DIV_IDLE.

**Working registers vs outputs:** working registers are separate from the `quotient`/`remainder` output registers. The outputs change only in DIV_FIX.

**Boundary conditions:**
- `en` while `ready`=0 is ignored; the latched operands are used.
- `flush`=1 in DIV_RUN or DIV_FIX: go to DIV_IDLE at the next edge. Outputs keep their previous values. `flush` has priority over the DIV_FIX output update.
- `flush` and `en` both high in DIV_IDLE: `en` is ignored.
- `nrst` low at any time: immediately DIV_IDLE, outputs 0, `ready`=1, working registers 0.

## Timing
- Normal operation: `ready` falls after E0 and is low for exactly 33 cycles (32 RUN + 1 FIX). Results are valid together with `ready` rising, after E33.
- Divide by zero or overflow: `ready` is low for exactly 1 cycle. Results are valid after E1.
- Back-to-back operations: `en` high in the first cycle `ready` is high is accepted at that edge. There is no dead cycle.
- There is no combinational path from inputs to outputs.

## Structure
- `common_types_pkg` gains:
  - `typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_t`
  - `localparam DIV_ITERS = 32`
- `divider_if.vh` defines the interface and its two modports.
- Single module `divider`. The shift-subtract step is small enough that no sub-module is warranted.

## Test plan
- Unsigned: 100 / 7, is_signed=0 → q=14, r=2; `ready` low exactly 33 cycles.
- Signed: 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- Divide by zero: 5 / 0 in both signed and unsigned modes → q=0xFFFFFFFF, r=5; `ready` low exactly 1 cycle.
- Overflow case, a=0x80000000, b=0xFFFFFFFF:
  - Signed → q=0x80000000, r=0, 1-cycle latency.
  - Unsigned → q=0, r=0x80000000, 33-cycle latency.
- Abort cases:
  - Complete 100/7 first. Then start 1000/3 and pulse `flush` during RUN iteration 5 → `ready` high next edge; outputs stay q=14, r=2.
  - Pull `nrst` low mid-RUN → outputs 0 and `ready`=1 without waiting for a clock edge.
- Handshake: hold `en` high continuously, changing the operands while busy → the first result reflects the operands latched at E0. The second operation is accepted on the cycle `ready` returns, with a total of 66 cycles for two normal divides.
